jesd204b_dl_tx: RTL and testbench
=================================

Name: jesd204b_dl_tx

Overview:
- Per-lane JESD204B data link layer transmitter; counterpart of the lane receiver.
- Sits between the transport-layer mapper and the 8b/10b encoder/serializer.
- Emits CGS (/K/) while the receiver requests sync, then the initial lane alignment sequence (ILAS), then user data with alignment character replacement.
- Handles 4 octets per clock; octet i occupies bits [8i+7:8i], and lower i is earlier in time.

Parameters:
- LANE_DATA_WIDTH, 32, lane word width; fixed at 4 octets.
- OCTETS_PER_FR, 5, F: octets per frame; F*K must be a multiple of 4.
- FRAMES_PER_MF, 4, K: frames per multiframe.
- ILAS_MF, 4, number of ILAS multiframes; must be at least 2.

Ports:
- clk  in  1  lane clock.
- reset  in  1  asynchronous, active-low reset.
- sync_request  in  1  receiver SYNC request; 1 = request CGS.
- LMFC  in  1  single-cycle pulse on the cycle that opens a multiframe.
- scramble_enable  in  1  selects the scrambled-mode replacement rules.
- cfg  in  112  ILAS link configuration octets 0..13; octet n = cfg[8n+7:8n].
- in  in  32  transport-layer data.
- in_ready  out  1  1 = `in` is consumed this cycle; high only in DATA.
- out  out  32  lane octets to the encoder.
- charisk  out  4  per-octet K-character flag.
- eof  out  4  per-octet end-of-frame flag, aligned with `out`.

Behaviour:
- Reset (reset=0, async) gives: state=CGS, out={4{8'hBC}}, charisk=4'hF, eof=0, in_ready=0, octet counter=0, last-octet register=0.
- All outputs are registered. A word on `in` that is accepted in cycle n appears on `out` in cycle n+1.
- Octet counter oc counts 0..F*K-1 in steps of 4 and wraps to 0.
  - It is forced to 0 on the cycle after an LMFC pulse accepted in CGS_WAIT.
  - Octet i of a word has index oc+i.
  - Octet i is end-of-frame when (oc+i) mod F = F-1.
  - Octet i is end-of-multiframe when oc+i = F*K-1.
- States:
  - CGS: out={4{BC}}, charisk=F. Leave for CGS_WAIT when sync_request=0.
  - CGS_WAIT: keep emitting K. On LMFC=1 with sync_request=0, go to ILAS with mf=0. The first ILAS word appears on the next cycle.
  - ILAS (mf=0..ILAS_MF-1), per octet:
    - idx 0: 8'h1C /R/, K.
    - idx F*K-1: 8'h7C /A/, K.
    - mf=1, idx 1: 8'h9C /Q/, K.
    - mf=1, idx 2..15: cfg octet (idx-2), D.
    - Every other octet: data (idx mod 256), D.
    - After the word containing idx F*K-1 of mf=ILAS_MF-1, go to DATA. in_ready rises in that same cycle, so the first DATA word follows the last ILAS word with no gap.
  - DATA: in_ready=1. Output `in` with replacement at frame ends only (below). The eof flags track oc in every state.
- Replacement when scramble_enable=0, at an end-of-frame octet d:
  - If d equals prev, emit 7C K when the octet is end-of-multiframe, else FC K.
  - Otherwise emit d, D.
  - prev always updates to the ORIGINAL d, never the substituted character.
  - Several frame ends in one word (F<4) are evaluated in order i=0..3, each using prev as updated by the lower octet.
  - prev resets to 0 on entry to DATA.
- Replacement when scramble_enable=1, at an end-of-frame octet d:
  - d=8'h7C at end-of-multiframe → 7C K.
  - d=8'hFC at a non-multiframe frame end → FC K.
  - Otherwise no replacement.
- Non-frame-end octets are passed unchanged with charisk=0.
- sync_request=1 in any state other than CGS goes to CGS on the next cycle; in_ready drops in that same cycle.
- An LMFC pulse arriving while sync_request=1 is ignored.
- LMFC pulses in ILAS or DATA do not disturb oc. Checking LMFC against oc=0 is the assertion's job; the RTL does not correct it.

Test Plan:
- Reset low mid-DATA → out=BCBCBCBC and charisk=F immediately, in_ready=0; stays in CGS while sync_request=1.
- sync_request falls, LMFC pulses 3 cycles later → K continues until that pulse. The next word has octet0=1C (charisk bit0=1), and octet 19 of each MF is 7C. For F=5,K=4 the ILAS lasts 20 cycles, and MF1 octets 1..15 = 9C followed by cfg octets 0..13.
- DATA, scramble off, F=5,K=4: frames whose last octet is 0x55 twice in a row → second becomes FC K. At idx 19 a repeat of 0x55 → 7C K. A third 0x55 after a replacement is also replaced, because the compare uses original data.
- DATA, scramble on: last octet 0x7C at idx 19 → 7C K. Value 0x55 repeated → passes as 55 D. Value 0xFC at idx 4 → FC K.
- sync_request rises during ILAS → CGS K on the next cycle, no data leaks. A later LMFC restarts the ILAS from mf=0.
- Param F=2,K=8: repeated end octets 0x11 at idx 1 and idx 3 in the same word → idx 3 becomes FC. eof=4'b1010 every cycle.

Source files
------------

// File: rtl/jesd204b_dl_tx.sv
// JESD204B per-lane data link transmitter.
// Emits CGS /K/ while the receiver requests sync, then the ILAS, then user data
// with end-of-frame alignment character replacement. Four octets per clock;
// octet 0 (bits [7:0]) is earliest in time. Every output is registered, and the
// registers describe the word currently on `out`.
module jesd204b_dl_tx #(
    parameter int unsigned LANE_DATA_WIDTH = 32,
    parameter int unsigned OCTETS_PER_FR   = 5,
    parameter int unsigned FRAMES_PER_MF   = 4,
    parameter int unsigned ILAS_MF         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sync_request,
    input  logic                       LMFC,
    input  logic                       scramble_enable,
    input  logic [111:0]               cfg,
    input  logic [LANE_DATA_WIDTH-1:0] in,
    output logic                       in_ready,
    output logic [LANE_DATA_WIDTH-1:0] out,
    output logic [3:0]                 charisk,
    output logic [3:0]                 eof
);

    localparam int unsigned FK   = OCTETS_PER_FR * FRAMES_PER_MF;
    localparam int unsigned OC_W = (FK > 1) ? $clog2(FK) : 1;
    localparam int unsigned MF_W = $clog2(ILAS_MF + 1);

    localparam logic [OC_W-1:0] OC_LAST = OC_W'(FK - 4);
    localparam logic [OC_W-1:0] OC_STEP = OC_W'(4);
    localparam logic [MF_W-1:0] MF_LAST = MF_W'(ILAS_MF - 1);
    localparam logic [MF_W-1:0] MF_CFG  = MF_W'(1);

    localparam logic [7:0] K_CHAR = 8'hBC;
    localparam logic [7:0] R_CHAR = 8'h1C;
    localparam logic [7:0] A_CHAR = 8'h7C;
    localparam logic [7:0] Q_CHAR = 8'h9C;
    localparam logic [7:0] F_CHAR = 8'hFC;

    typedef enum logic [1:0] {
        StCgs,
        StCgsWait,
        StIlas,
        StData
    } state_e;

    state_e state_q, state_d;

    logic [OC_W-1:0]            oc_q, oc_d;
    logic [MF_W-1:0]            mf_q, mf_d;
    logic [7:0]                 prev_q, prev_d;
    logic [LANE_DATA_WIDTH-1:0] out_q, out_d;
    logic [3:0]                 charisk_q, charisk_d;
    logic [3:0]                 eof_q, eof_d;
    logic                       in_ready_q, in_ready_d;

    // Per-octet scratch for the word builder.
    int unsigned idx_w;
    logic [7:0]  prev_w;
    logic [7:0]  oct_w;
    logic [7:0]  char_w;
    logic        k_w;
    logic        is_eof_w;
    logic        is_eomf_w;
    logic [6:0]  cfg_sel_w;

    // Next state, octet counter and ILAS multiframe counter.
    always_comb begin
        state_d = state_q;
        oc_d    = (oc_q == OC_LAST) ? '0 : oc_q + OC_STEP;
        mf_d    = mf_q;

        unique case (state_q)
            StCgs: begin
                if (!sync_request) begin
                    state_d = StCgsWait;
                end
            end
            StCgsWait: begin
                if (LMFC && !sync_request) begin
                    state_d = StIlas;
                    oc_d    = '0;
                    mf_d    = '0;
                end
            end
            StIlas: begin
                if (oc_q == OC_LAST) begin
                    if (mf_q == MF_LAST) begin
                        state_d = StData;
                    end else begin
                        mf_d = mf_q + MF_W'(1);
                    end
                end
            end
            StData: begin
            end
        endcase

        // Sync request overrides everything and holds the link in CGS.
        if (sync_request) begin
            state_d = StCgs;
        end

        // Ready one cycle ahead: the word loaded after next is user data.
        in_ready_d = (state_d == StData) ||
                     ((state_d == StIlas) && (oc_d == OC_LAST) && (mf_d == MF_LAST));
    end

    // Build the word loaded at the next edge from the next state and octet index.
    always_comb begin
        out_d     = '0;
        charisk_d = '0;
        eof_d     = '0;
        idx_w     = '0;
        oct_w     = '0;
        char_w    = K_CHAR;
        k_w       = 1'b1;
        is_eof_w  = 1'b0;
        is_eomf_w = 1'b0;
        cfg_sel_w = '0;
        // Comparison history restarts with every entry into DATA.
        prev_w    = (state_q == StData) ? prev_q : 8'h00;

        for (int i = 0; i < 4; i++) begin
            idx_w     = 32'(oc_d) + 32'(i);
            oct_w     = in[8*i +: 8];
            is_eof_w  = (idx_w % OCTETS_PER_FR) == (OCTETS_PER_FR - 1);
            is_eomf_w = idx_w == (FK - 1);
            cfg_sel_w = 7'((idx_w - 2) * 8);
            char_w    = K_CHAR;
            k_w       = 1'b1;

            unique case (state_d)
                StCgs, StCgsWait: begin
                end
                StIlas: begin
                    if (idx_w == 0) begin
                        char_w = R_CHAR;
                    end else if (is_eomf_w) begin
                        char_w = A_CHAR;
                    end else if ((mf_d == MF_CFG) && (idx_w == 1)) begin
                        char_w = Q_CHAR;
                    end else if ((mf_d == MF_CFG) && (idx_w >= 2) && (idx_w <= 15)) begin
                        char_w = cfg[cfg_sel_w +: 8];
                        k_w    = 1'b0;
                    end else begin
                        char_w = idx_w[7:0];
                        k_w    = 1'b0;
                    end
                end
                StData: begin
                    char_w = oct_w;
                    k_w    = 1'b0;
                    if (is_eof_w) begin
                        if (scramble_enable) begin
                            if ((is_eomf_w && (oct_w == A_CHAR)) ||
                                (!is_eomf_w && (oct_w == F_CHAR))) begin
                                k_w = 1'b1;
                            end
                        end else if (oct_w == prev_w) begin
                            char_w = is_eomf_w ? A_CHAR : F_CHAR;
                            k_w    = 1'b1;
                        end
                        // History tracks the original octet, not the substitute.
                        prev_w = oct_w;
                    end
                end
            endcase

            out_d[8*i +: 8] = char_w;
            charisk_d[i]    = k_w;
            eof_d[i]        = is_eof_w;
        end

        prev_d = (state_d == StData) ? prev_w : 8'h00;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StCgs;
            oc_q       <= '0;
            mf_q       <= '0;
            prev_q     <= 8'h00;
            out_q      <= {(LANE_DATA_WIDTH / 8){K_CHAR}};
            charisk_q  <= 4'hF;
            eof_q      <= 4'h0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            oc_q       <= oc_d;
            mf_q       <= mf_d;
            prev_q     <= prev_d;
            out_q      <= out_d;
            charisk_q  <= charisk_d;
            eof_q      <= eof_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out      = out_q;
    assign charisk  = charisk_q;
    assign eof      = eof_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_jesd204b_dl_tx.sv
// Bench for jesd204b_dl_tx: two lanes (F=5,K=4 and F=2,K=8) driven with the same
// stimulus. A link-level model predicts each output word into a queue; a monitor
// pops and compares on the falling edge.
module tb_jesd204b_dl_tx;

    localparam int unsigned ILAS_MF = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sync_request;
    logic         lmfc;
    logic         scramble_enable;
    logic [111:0] cfg;
    logic [31:0]  din;

    logic         rdy0, rdy1;
    logic [31:0]  out0, out1;
    logic [3:0]   kis0, kis1;
    logic [3:0]   eof0, eof1;

    always #5 clk = ~clk;

    jesd204b_dl_tx #(
        .LANE_DATA_WIDTH(32),
        .OCTETS_PER_FR  (5),
        .FRAMES_PER_MF  (4),
        .ILAS_MF        (ILAS_MF)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .sync_request   (sync_request),
        .LMFC           (lmfc),
        .scramble_enable(scramble_enable),
        .cfg            (cfg),
        .in             (din),
        .in_ready       (rdy0),
        .out            (out0),
        .charisk        (kis0),
        .eof            (eof0)
    );

    jesd204b_dl_tx #(
        .LANE_DATA_WIDTH(32),
        .OCTETS_PER_FR  (2),
        .FRAMES_PER_MF  (8),
        .ILAS_MF        (ILAS_MF)
    ) u_dut_f2 (
        .clk            (clk),
        .reset          (reset),
        .sync_request   (sync_request),
        .LMFC           (lmfc),
        .scramble_enable(scramble_enable),
        .cfg            (cfg),
        .in             (din),
        .in_ready       (rdy1),
        .out            (out1),
        .charisk        (kis1),
        .eof            (eof1)
    );

    typedef struct packed {
        logic [31:0] out;
        logic [3:0]  k;
        logic [3:0]  eof;
        logic        rdy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t rst_e;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Link model: octet position in the multiframe, octets since ILAS start.
    bit          active[2];
    int unsigned n_oct[2];
    int unsigned pos[2];
    logic [7:0]  prev[2];
    bit          psl;  // sync_request was low at the previous edge

    task automatic compare(input string name, input exp_t act, input exp_t want);
        checks++;
        if (act === want) begin
            passes++;
        end else begin
            $display("FAIL %s t=%0t got out=%h k=%h eof=%h rdy=%b want out=%h k=%h eof=%h rdy=%b",
                     name, $time, act.out, act.k, act.eof, act.rdy,
                     want.out, want.k, want.eof, want.rdy);
        end
    endtask

    task automatic model_step(input int u, input int unsigned f, input int unsigned kk,
                              output exp_t e);
        int unsigned fk, ilas_len, idx, g;
        logic [7:0]  d, o;
        logic        ko;
        e        = '0;
        fk       = f * kk;
        ilas_len = ILAS_MF * fk;
        if (sync_request) begin
            active[u] = 1'b0;
            pos[u]    = (pos[u] + 4) % fk;
        end else if (!active[u] && psl && lmfc) begin
            active[u] = 1'b1;
            n_oct[u]  = 0;
            pos[u]    = 0;
        end else begin
            if (active[u]) n_oct[u] += 4;
            pos[u] = (pos[u] + 4) % fk;
        end
        e.rdy = active[u] && (n_oct[u] + 4 >= ilas_len);
        for (int i = 0; i < 4; i++) begin
            idx      = pos[u] + i;
            g        = n_oct[u] + i;
            e.eof[i] = (idx % f) == f - 1;
            o        = 8'hBC;
            ko       = 1'b1;
            if (!active[u]) begin
                o  = 8'hBC;
                ko = 1'b1;
            end else if (g < ilas_len) begin
                if (idx == 0) o = 8'h1C;
                else if (idx == fk - 1) o = 8'h7C;
                else if (g / fk == 1 && idx == 1) o = 8'h9C;
                else if (g / fk == 1 && idx >= 2 && idx <= 15) begin
                    o  = cfg[8*(idx-2) +: 8];
                    ko = 1'b0;
                end else begin
                    o  = 8'(idx);
                    ko = 1'b0;
                end
            end else begin
                if (g == ilas_len) prev[u] = 8'h00;
                d  = din[8*i +: 8];
                o  = d;
                ko = 1'b0;
                if (idx % f == f - 1) begin
                    if (scramble_enable) begin
                        ko = (idx == fk - 1) ? (d == 8'h7C) : (d == 8'hFC);
                    end else if (d == prev[u]) begin
                        o  = (idx == fk - 1) ? 8'h7C : 8'hFC;
                        ko = 1'b1;
                    end
                    prev[u] = d;
                end
            end
            e.out[8*i +: 8] = o;
            e.k[i]          = ko;
        end
    endtask

    // Reference model: predict the word each edge loads.
    always @(posedge clk) begin
        exp_t e0;
        exp_t e1;
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                active[u] = 1'b0;
                n_oct[u]  = 0;
                pos[u]    = 0;
                prev[u]   = 8'h00;
            end
            psl = 1'b0;
            q0.push_back(rst_e);
            q1.push_back(rst_e);
        end else begin
            model_step(0, 5, 4, e0);
            model_step(1, 2, 8, e1);
            q0.push_back(e0);
            q1.push_back(e1);
            psl = !sync_request;
        end
    end

    // Monitor: compare the presented word against the oldest prediction.
    always @(negedge clk) begin
        if (q0.size() > 0) compare("lane_f5k4", {out0, kis0, eof0, rdy0}, q0.pop_front());
        if (q1.size() > 0) compare("lane_f2k8", {out1, kis1, eof1, rdy1}, q1.pop_front());
    end

    function automatic logic [31:0] gen_word(input int unsigned mode);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 4))
                0:       w[8*i +: 8] = 8'h55;
                1:       w[8*i +: 8] = 8'h7C;
                2:       w[8*i +: 8] = 8'hFC;
                3:       w[8*i +: 8] = 8'h11;
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        if (mode == 1) w = 32'h5555_5555;
        if (mode == 2) begin
            w[15:8]  = 8'h11;
            w[31:24] = 8'h11;
        end
        return w;
    endfunction

    task automatic cyc(input int unsigned mode);
        @(posedge clk);
        #1;
        lmfc = 1'b0;
        din  = gen_word(mode);
    endtask

    initial begin
        rst_e.out       = {4{8'hBC}};
        rst_e.k         = 4'hF;
        rst_e.eof       = 4'h0;
        rst_e.rdy       = 1'b0;
        reset           = 1'b0;
        sync_request    = 1'b1;
        lmfc            = 1'b0;
        scramble_enable = 1'b0;
        din             = '0;
        for (int i = 0; i < 14; i++) cfg[8*i +: 8] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) cyc(0);
        lmfc = 1'b1;                       // ignored while sync is requested
        repeat (3) cyc(0);
        sync_request = 1'b0;
        repeat (3) cyc(0);
        lmfc = 1'b1;                       // opens ILAS
        repeat (24) cyc(0);
        repeat (40) cyc(0);
        lmfc = 1'b1;                       // LMFC in DATA must not disturb anything
        repeat (6) cyc(1);
        scramble_enable = 1'b1;
        repeat (40) cyc(0);
        repeat (6) cyc(1);
        scramble_enable = 1'b0;
        repeat (10) cyc(2);

        // Asynchronous reset in the middle of DATA.
        @(negedge clk);
        #1;
        reset        = 1'b0;
        sync_request = 1'b1;
        #1;
        compare("async_reset_f5k4", {out0, kis0, eof0, rdy0}, rst_e);
        compare("async_reset_f2k8", {out1, kis1, eof1, rdy1}, rst_e);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) cyc(0);

        // Start ILAS, abort it with a sync request, then restart.
        sync_request = 1'b0;
        repeat (3) cyc(0);
        lmfc = 1'b1;
        repeat (8) cyc(0);
        sync_request = 1'b1;
        cyc(0);
        lmfc = 1'b1;
        cyc(0);
        sync_request = 1'b0;
        repeat (3) cyc(0);
        lmfc = 1'b1;
        repeat (30) cyc(0);

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
